// File: rtl/wam_game_engine.sv
// Whack-a-mole game sequencer: mole selection, gap/on timing per level,
// hit judging, hit/miss/flick counters and four game modes.
module wam_game_engine #(
  parameter int unsigned NUM_MOLES       = 9,
  parameter int unsigned TICKS_PER_UNIT  = 12_500_000,
  parameter int unsigned NORMAL_FLICKS   = 25,
  parameter int unsigned EXTENDED_FLICKS = 50,
  parameter int unsigned TIMED_UNITS     = 240,
  parameter int unsigned LEVEL_UP_HITS   = 5,
  parameter int unsigned CNT_W           = 7
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           difficulty,
  input  logic [3:0]           gamemode,
  input  logic                 extended,
  input  logic [15:0]          seed,
  input  logic                 hit_valid,
  input  logic [3:0]           hit_idx,
  output logic [NUM_MOLES-1:0] moles,
  output logic [CNT_W-1:0]     hits,
  output logic [CNT_W-1:0]     misses,
  output logic [CNT_W-1:0]     flicks,
  output logic [1:0]           level,
  output logic                 game_over,
  output logic                 win,
  output logic                 busy
);

  localparam longint unsigned MAX_TICKS  = 64'd8 * 64'(TICKS_PER_UNIT);
  localparam longint unsigned GAME_TICKS = 64'(TIMED_UNITS) * 64'(TICKS_PER_UNIT);
  localparam int unsigned TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned GW = (GAME_TICKS > 1) ? $clog2(GAME_TICKS) : 1;
  localparam int unsigned LW = (LEVEL_UP_HITS > 1) ? $clog2(LEVEL_UP_HITS + 1) : 1;
  localparam logic [NUM_MOLES-1:0] ONE_MOLE = NUM_MOLES'(1);

  typedef enum logic [1:0] {IDLE, GAP, ON, DONE} state_t;
  typedef enum logic [1:0] {M_NORMAL, M_TIMED, M_DEATH, M_CONT} mode_t;

  state_t               state, state_n;
  mode_t                mode, mode_n;
  logic                 ext, ext_n;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [GW-1:0]        gtimer, gtimer_n;
  logic [15:0]          lfsr;
  logic [3:0]           lit_idx, lit_idx_n;
  logic [LW-1:0]        lvl_hits, lvl_hits_n;
  logic [NUM_MOLES-1:0] moles_n;
  logic [CNT_W-1:0]     hits_n, misses_n, flicks_n;
  logic [1:0]           level_n;
  logic                 win_n;

  logic [TW-1:0]        gap_lim, on_lim;
  logic [3:0]           pick;
  logic [CNT_W-1:0]     flick_limit;
  logic                 timed, game_end, correct, wrong, timeout, resolve;

  function automatic logic [1:0] decode_level(input logic [3:0] d);
    case (d)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic mode_t decode_mode(input logic [3:0] m);
    case (m)
      4'b0010: return M_TIMED;
      4'b0100: return M_DEATH;
      4'b1000: return M_CONT;
      default: return M_NORMAL;
    endcase
  endfunction

  function automatic logic [TW-1:0] ticks(input logic [3:0] units);
    return TW'(64'(units) * 64'(TICKS_PER_UNIT) - 64'd1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  always_comb begin
    gap_lim = '0;
    on_lim  = '0;
    unique case (level)
      2'd0: begin gap_lim = ticks(4'd8); on_lim = ticks(4'd8); end
      2'd1: begin gap_lim = ticks(4'd4); on_lim = ticks(4'd4); end
      2'd2: begin gap_lim = ticks(4'd2); on_lim = ticks(4'd4); end
      2'd3: begin gap_lim = ticks(4'd1); on_lim = ticks(4'd2); end
    endcase
  end

  assign busy      = (state == GAP) || (state == ON);
  assign game_over = (state == DONE);

  always_comb begin
    state_n     = state;
    mode_n      = mode;
    ext_n       = ext;
    tcnt_n      = '0;
    gtimer_n    = gtimer;
    lit_idx_n   = lit_idx;
    lvl_hits_n  = lvl_hits;
    moles_n     = moles;
    hits_n      = hits;
    misses_n    = misses;
    flicks_n    = flicks;
    level_n     = level;
    win_n       = win;
    resolve     = 1'b0;
    pick        = 4'(lfsr[7:0] % 8'(NUM_MOLES));
    flick_limit = CNT_W'(ext ? EXTENDED_FLICKS : NORMAL_FLICKS);
    timed       = (mode == M_TIMED);
    game_end    = timed && (gtimer == '0);
    correct     = hit_valid && (hit_idx == lit_idx);
    wrong       = hit_valid && !correct;
    timeout     = (tcnt == on_lim);

    if (timed && (gtimer != '0) && busy)
      gtimer_n = gtimer - 1'b1;

    if (start) begin
      mode_n     = decode_mode(gamemode);
      ext_n      = extended;
      hits_n     = '0;
      misses_n   = '0;
      flicks_n   = '0;
      lvl_hits_n = '0;
      win_n      = 1'b0;
      moles_n    = '0;
      level_n    = (decode_mode(gamemode) == M_CONT) ? 2'd0 : decode_level(difficulty);
      gtimer_n   = GW'(GAME_TICKS - 64'd1);
      state_n    = GAP;
    end else begin
      unique case (state)
        IDLE: moles_n = '0;
        GAP: begin
          if (game_end) begin
            state_n = DONE;
            win_n   = {hits, 1'b0} >= {1'b0, flicks};
          end else if (tcnt == gap_lim) begin
            state_n   = ON;
            lit_idx_n = pick;
            moles_n   = ONE_MOLE << pick;
            flicks_n  = sat_inc(flicks);
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        ON: begin
          // Timed-game expiry outranks any hit or timeout in the same cycle.
          if (game_end) begin
            state_n = DONE;
            moles_n = '0;
            win_n   = {hits, 1'b0} >= {1'b0, flicks};
          end else if (correct) begin
            hits_n  = sat_inc(hits);
            moles_n = '0;
            resolve = 1'b1;
            if (mode == M_CONT) begin
              if (lvl_hits == LW'(LEVEL_UP_HITS - 1)) begin
                lvl_hits_n = '0;
                if (level != 2'd3) level_n = level + 2'd1;
              end else begin
                lvl_hits_n = lvl_hits + 1'b1;
              end
            end
          end else begin
            if (wrong)   misses_n = sat_inc(misses_n);
            if (timeout) misses_n = sat_inc(misses_n);
            if ((wrong || timeout) && (mode == M_DEATH)) begin
              state_n = DONE;
              moles_n = '0;
              win_n   = 1'b0;
            end else if (timeout) begin
              moles_n = '0;
              resolve = 1'b1;
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        DONE: ;
      endcase
    end

    // Flick count was already bumped when the mole lit, so compare it directly.
    if (resolve) begin
      if (!timed && (flicks == flick_limit)) begin
        state_n = DONE;
        if (mode == M_DEATH) win_n = (misses_n == '0);
        else                 win_n = {hits_n, 1'b0} >= {1'b0, flicks};
      end else begin
        state_n = GAP;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      mode     <= M_NORMAL;
      ext      <= 1'b0;
      tcnt     <= '0;
      gtimer   <= '0;
      lit_idx  <= '0;
      lvl_hits <= '0;
      moles    <= '0;
      hits     <= '0;
      misses   <= '0;
      flicks   <= '0;
      level    <= decode_level(difficulty);
      win      <= 1'b0;
      lfsr     <= (seed == '0) ? 16'h0001 : seed;
    end else begin
      state    <= state_n;
      mode     <= mode_n;
      ext      <= ext_n;
      tcnt     <= tcnt_n;
      gtimer   <= gtimer_n;
      lit_idx  <= lit_idx_n;
      lvl_hits <= lvl_hits_n;
      moles    <= moles_n;
      hits     <= hits_n;
      misses   <= misses_n;
      flicks   <= flicks_n;
      level    <= level_n;
      win      <= win_n;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

endmodule

// File: tb/tb_wam_game_engine.sv
// Directed bench for wam_game_engine: cycle table plus continuity/timed/reset sequences.
module tb_wam_game_engine;
  localparam int NM = 9;

  logic          CLOCK_50 = 1'b0;
  logic          reset, start, extended, hit_valid;
  logic [3:0]    difficulty, gamemode, hit_idx;
  logic [15:0]   seed;
  logic [NM-1:0] moles;
  logic [6:0]    hits, misses, flicks;
  logic [1:0]    level;
  logic          game_over, win, busy;

  int tests = 0;
  int fails = 0;
  logic [15:0] lfsr_m, lfsr_prev;

  wam_game_engine #(
    .NUM_MOLES(NM), .TICKS_PER_UNIT(2), .NORMAL_FLICKS(4), .EXTENDED_FLICKS(6),
    .TIMED_UNITS(10), .LEVEL_UP_HITS(2), .CNT_W(7)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .difficulty(difficulty),
    .gamemode(gamemode), .extended(extended), .seed(seed), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .moles(moles), .hits(hits), .misses(misses), .flicks(flicks),
    .level(level), .game_over(game_over), .win(win), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference LFSR: lfsr_prev holds the value seen during the previous cycle.
  always @(posedge CLOCK_50) begin
    lfsr_prev <= lfsr_m;
    if (reset) lfsr_m <= (seed == 16'h0) ? 16'h0001 : seed;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  typedef struct {
    bit       st;
    logic [3:0] mode;
    int       hit;   // 0 none, 1 lit key, 2 wrong key, 3 out-of-range key
    bit       busy;
    bit       lit;
    int       fl, hi, mi;
    bit       over, win;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit st, input logic [3:0] mode, input int hit, input bit b,
                     input bit lit, input int fl, input int hi, input int mi,
                     input bit over, input bit w);
    vec_t v;
    v.st = st; v.mode = mode; v.hit = hit; v.busy = b; v.lit = lit;
    v.fl = fl; v.hi = hi; v.mi = mi; v.over = over; v.win = w;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic int pick_of(input logic [15:0] l);
    return int'(l[7:0]) % NM;
  endfunction

  function automatic int onehot(input int idx);
    return 1 << idx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [3:0] MN = 4'b0001;
  localparam logic [3:0] MD = 4'b0100;

  vec_t v;
  int   exp_idx, idx, n;
  bit   prev_lit;
  int   gaps[6] = '{16, 16, 8, 8, 4, 4};
  int   lvls[6] = '{0, 1, 1, 2, 2, 3};

  initial begin
    // st mode hit | busy lit flicks hits misses over win
    add(1, MN, 0, 0, 0, 0, 0, 0, 0, 0);  // 0
    add(0, MN, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, MN, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, MN, 0, 1, 1, 1, 0, 0, 0, 0);  // 3: first mole
    add(0, MN, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, MN, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, MN, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, MN, 0, 1, 0, 1, 0, 1, 0, 0);  // 7: timeout
    add(0, MN, 0, 1, 0, 1, 0, 1, 0, 0);
    add(0, MN, 0, 1, 1, 2, 0, 1, 0, 0);  // 9
    add(0, MN, 0, 1, 1, 2, 0, 1, 0, 0);
    add(0, MN, 1, 1, 1, 2, 0, 1, 0, 0);  // 11: correct hit
    add(0, MN, 1, 1, 0, 2, 1, 1, 0, 0);  // 12: hit in GAP ignored
    add(0, MN, 0, 1, 0, 2, 1, 1, 0, 0);
    add(0, MN, 3, 1, 1, 3, 1, 1, 0, 0);  // 14: out-of-range key
    add(0, MN, 0, 1, 1, 3, 1, 2, 0, 0);
    add(0, MN, 0, 1, 1, 3, 1, 2, 0, 0);
    add(0, MN, 0, 1, 1, 3, 1, 2, 0, 0);
    add(0, MN, 0, 1, 0, 3, 1, 3, 0, 0);  // 18
    add(0, MN, 0, 1, 0, 3, 1, 3, 0, 0);
    add(0, MN, 1, 1, 1, 4, 1, 3, 0, 0);  // 20: hit on light cycle
    add(0, MN, 0, 0, 0, 4, 2, 3, 1, 1);  // 21: flick limit
    add(1, MD, 0, 0, 0, 4, 2, 3, 1, 1);  // 22: restart deathmatch
    add(0, MD, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, MD, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, MD, 2, 1, 1, 1, 0, 0, 0, 0);  // 25: wrong key
    add(0, MD, 0, 0, 0, 1, 0, 1, 1, 0);
    add(1, MN, 0, 0, 0, 1, 0, 1, 1, 0);  // 27: restart normal
    add(0, MN, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, MN, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, MN, 1, 1, 1, 1, 0, 0, 0, 0);  // 30
    add(0, MN, 0, 1, 0, 1, 1, 0, 0, 0);
    add(0, MN, 0, 1, 0, 1, 1, 0, 0, 0);
    add(0, MN, 0, 1, 1, 2, 1, 0, 0, 0);  // 33
    add(0, MN, 0, 1, 1, 2, 1, 0, 0, 0);
    add(0, MN, 0, 1, 1, 2, 1, 0, 0, 0);
    add(0, MN, 0, 1, 1, 2, 1, 0, 0, 0);
    add(0, MN, 0, 1, 0, 2, 1, 1, 0, 0);  // 37
    add(0, MN, 0, 1, 0, 2, 1, 1, 0, 0);
    add(0, MN, 1, 1, 1, 3, 1, 1, 0, 0);  // 39
    add(0, MN, 0, 1, 0, 3, 2, 1, 0, 0);
    add(0, MN, 0, 1, 0, 3, 2, 1, 0, 0);
    add(0, MN, 0, 1, 1, 4, 2, 1, 0, 0);  // 42
    add(0, MN, 0, 1, 1, 4, 2, 1, 0, 0);
    add(0, MN, 0, 1, 1, 4, 2, 1, 0, 0);
    add(0, MN, 0, 1, 1, 4, 2, 1, 0, 0);
    add(0, MN, 0, 0, 0, 4, 2, 2, 1, 1);  // 46: flick 4 timed out
    add(0, MN, 0, 0, 0, 4, 2, 2, 1, 1);

    reset = 1; start = 0; hit_valid = 0; hit_idx = 0; extended = 0;
    seed = 16'hACE1; difficulty = 4'b1000; gamemode = MN;
    step(); step();
    chk("reset moles", int'(moles), 0);
    chk("reset hits", int'(hits), 0);
    chk("reset misses", int'(misses), 0);
    chk("reset flicks", int'(flicks), 0);
    chk("reset level", int'(level), 3);
    chk("reset game_over", int'(game_over), 0);
    chk("reset win", int'(win), 0);
    chk("reset busy", int'(busy), 0);
    reset = 0;

    exp_idx = 0;
    prev_lit = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.lit && !prev_lit) exp_idx = pick_of(lfsr_prev);
      prev_lit = v.lit;
      chk($sformatf("row%0d busy", i), int'(busy), int'(v.busy));
      chk($sformatf("row%0d moles", i), int'(moles), v.lit ? onehot(exp_idx) : 0);
      chk($sformatf("row%0d flicks", i), int'(flicks), v.fl);
      chk($sformatf("row%0d hits", i), int'(hits), v.hi);
      chk($sformatf("row%0d misses", i), int'(misses), v.mi);
      chk($sformatf("row%0d game_over", i), int'(game_over), int'(v.over));
      chk($sformatf("row%0d win", i), int'(win), int'(v.win));
      start = v.st;
      gamemode = v.mode;
      difficulty = 4'b1000;
      extended = 0;
      hit_valid = (v.hit != 0);
      hit_idx = (v.hit == 1) ? 4'(exp_idx) : (v.hit == 2) ? 4'((exp_idx + 1) % NM) : 4'd15;
      step();
    end
    start = 0; hit_valid = 0;

    // Continuity with extended flicks: level climbs every 2 hits, gap shrinks.
    start = 1; gamemode = 4'b1000; difficulty = 4'b0100; extended = 1;
    step();
    start = 0;
    chk("cont level at start", int'(level), 0);
    chk("cont busy", int'(busy), 1);
    for (int f = 0; f < 6; f++) begin
      n = 0;
      while (moles == '0 && n < 40) begin step(); n++; end
      chk($sformatf("cont gap%0d", f), n, gaps[f]);
      idx = pick_of(lfsr_prev);
      chk($sformatf("cont mole%0d", f), int'(moles), onehot(idx));
      hit_valid = 1; hit_idx = 4'(idx);
      step();
      hit_valid = 0;
      chk($sformatf("cont hits%0d", f), int'(hits), f + 1);
      chk($sformatf("cont level%0d", f), int'(level), lvls[f]);
    end
    chk("cont game_over", int'(game_over), 1);
    chk("cont win", int'(win), 1);
    chk("cont flicks", int'(flicks), 6);
    chk("cont misses", int'(misses), 0);

    // Timed mode, L1, zero seed; start held with reset must be ignored.
    reset = 1; seed = 16'h0000; difficulty = 4'b0001; start = 1; gamemode = 4'b0010; extended = 0;
    step(); step();
    chk("timed reset level", int'(level), 0);
    chk("timed reset busy", int'(busy), 0);
    reset = 0;
    step();
    start = 0;
    chk("timed busy", int'(busy), 1);
    repeat (15) step();
    chk("timed gap end moles", int'(moles), 0);
    step();
    idx = pick_of(lfsr_prev);
    chk("timed mole", int'(moles), onehot(idx));
    chk("timed flicks", int'(flicks), 1);
    repeat (3) step();
    chk("timed before expiry over", int'(game_over), 0);
    chk("timed before expiry moles", int'(moles), onehot(idx));
    step();
    chk("timed expiry over", int'(game_over), 1);
    chk("timed expiry moles", int'(moles), 0);
    chk("timed expiry misses", int'(misses), 0);
    chk("timed expiry flicks", int'(flicks), 1);
    chk("timed expiry win", int'(win), 0);
    chk("timed expiry busy", int'(busy), 0);
    hit_valid = 1; hit_idx = 4'(idx);
    step();
    hit_valid = 0;
    chk("done hit ignored", int'(hits), 0);
    chk("done held", int'(game_over), 1);
    start = 1;
    step();
    start = 0;
    chk("restart hits", int'(hits), 0);
    chk("restart flicks", int'(flicks), 0);
    chk("restart misses", int'(misses), 0);
    chk("restart busy", int'(busy), 1);
    chk("restart over", int'(game_over), 0);
    n = 0;
    while (moles == '0 && n < 40) begin step(); n++; end
    chk("restart gap", n, 16);
    idx = pick_of(lfsr_prev);
    step();
    reset = 1; start = 1; hit_valid = 1; hit_idx = 4'(idx); difficulty = 4'b0101;
    step();
    reset = 0; start = 0; hit_valid = 0;
    chk("midgame reset moles", int'(moles), 0);
    chk("midgame reset busy", int'(busy), 0);
    chk("midgame reset hits", int'(hits), 0);
    chk("midgame reset flicks", int'(flicks), 0);
    chk("midgame reset level", int'(level), 1);
    step();
    chk("idle after reset busy", int'(busy), 0);
    chk("idle after reset over", int'(game_over), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wam_game_engine.md
Name: wam_game_engine

Overview:
Parametrised whack-a-mole game engine. It replaces the fixed 9-light, setting-only top level with a complete game sequencer. It picks moles pseudo-randomly, times gap and on windows per difficulty level, judges keypad hits, and keeps hit, miss and flick counters. Four game modes are implemented. It sits between the switch/keypad front end and the LED/score display drivers.

Parameters:
NUM_MOLES, 9, number of mole lights/keys (2..16)
TICKS_PER_UNIT, 12_500_000, clock cycles per timing unit (0.25 s at 50 MHz)
NORMAL_FLICKS, 25, flicks per game when extended=0
EXTENDED_FLICKS, 50, flicks per game when extended=1
TIMED_UNITS, 240, game length in units in timed mode (60 s)
LEVEL_UP_HITS, 5, hits per level increment in continuity mode
CNT_W, 7, width of the hits/misses/flicks counters

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE and loads the LFSR seed
start  in  1  single-cycle pulse; starts a game, or restarts one in progress
difficulty  in  4  one-hot level select, [0]=L1..[3]=L4; non-one-hot selects L2
gamemode  in  4  one-hot mode select, [0]=normal [1]=timed [2]=deathmatch [3]=continuity; non-one-hot selects normal
extended  in  1  0=NORMAL_FLICKS, 1=EXTENDED_FLICKS
seed  in  16  LFSR seed, sampled only while reset=1
hit_valid  in  1  single-cycle pulse, a key was pressed
hit_idx  in  4  index of the pressed key, qualified by hit_valid
moles  out  NUM_MOLES  one-hot lit mole, or all zero
hits  out  CNT_W  correct hits
misses  out  CNT_W  timeouts plus wrong-key presses
flicks  out  CNT_W  moles shown so far
level  out  2  active level minus 1
game_over  out  1  high in DONE
win  out  1  result, valid while game_over=1
busy  out  1  high in GAP or ON

Behaviour:
- Reset values: moles=0, hits=misses=flicks=0, level=per difficulty, game_over=0, win=0, busy=0, state=IDLE. LFSR is loaded with the seed value; a seed of 0 is replaced by 16'h0001.
- Level timing, in units (gap/on): L1=8/8, L2=4/4, L3=2/4, L4=1/2. GAP lasts exactly gap*TICKS_PER_UNIT cycles; a mole stays lit exactly on*TICKS_PER_UNIT cycles.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle outside reset. Mole index = lfsr[7:0] mod NUM_MOLES, sampled on GAP exit.
- start (any state, reset=0): latch difficulty, gamemode and extended; clear all counters; set level from difficulty (continuity mode forces L1). Go to GAP next cycle and clear moles immediately. The LFSR is not reseeded.
- States:
  - IDLE: moles=0; start -> GAP.
  - GAP: when the gap time expires, light the chosen mole, flicks+=1 -> ON.
  - ON, hit_valid with hit_idx == lit index: hits+=1, moles=0 next cycle. Go to DONE if the flick limit is reached, else GAP.
  - ON, hit_valid with the wrong index (or hit_idx >= NUM_MOLES): misses+=1, the mole stays lit, the on timer continues. In deathmatch -> DONE, win=0.
  - ON, timeout: misses+=1, moles=0. In deathmatch -> DONE, win=0; otherwise apply the flick limit check, then GAP.
  - DONE: game_over=1, outputs held; start -> GAP (new game).
- hit_valid outside ON is ignored and changes no counter.
- A correct hit in the same cycle as the timeout counts as a hit, not a miss.
- Flick limit (normal, deathmatch, continuity): the game ends after flick NORMAL_FLICKS or EXTENDED_FLICKS resolves.
- Timed mode:
  - There is no flick limit; a game timer of TIMED_UNITS*TICKS_PER_UNIT cycles starts on entry to GAP after start.
  - On expiry the game goes to DONE from any state; a lit mole is extinguished and is not counted as a miss.
  - Counters saturate at 2^CNT_W-1.
- Continuity mode: after every LEVEL_UP_HITS-th hit, level increments (saturating at L4). The new timing applies from the next GAP.
- win on the DONE transition:
  - deathmatch: win=1 iff misses==0.
  - all other modes: win=1 iff 2*hits >= flicks.
- Reset mid-game wins over start and hit_valid in the same cycle.

Test Plan:
- TICKS_PER_UNIT=2, L4, normal, seed=16'hACE1, start at cycle 0 -> busy=1 at cycle 1; a mole lights at cycle 3 with flicks=1 and stays lit exactly 4 cycles; with no hit, misses=1 and moles=0.
- Same setup, correct hit_idx pulsed 2 cycles after the mole lights -> hits=1, moles=0 next cycle, next mole lights 2 cycles later.
- Deathmatch, first mole lit, wrong hit_idx -> misses=1, game_over=1, win=0, moles=0 next cycle.
- Normal, NORMAL_FLICKS=4, alternate correct hit and timeout -> after flick 4 resolves: game_over=1, hits=2, misses=2, flicks=4, win=1.
- Continuity, LEVEL_UP_HITS=2, always hit correctly -> level goes 0->1 after hit 2 and ->2 after hit 4; gap shrinks from 16 to 8 to 4 cycles.
- Timed, TIMED_UNITS=10, TICKS_PER_UNIT=2, start -> game_over=1 exactly 20 cycles after GAP entry with a mole lit, misses unchanged; start in DONE -> counters=0, busy=1; reset mid-ON -> moles=0, IDLE.
